zlib_enc_ctrl: RTL

//  Sequences the fixed-Huffman zlib stream encoder (bsZlib) for one frame at a time.

---
 rtl/zlib_enc_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/zlib_enc_ctrl.sv
// Frame sequencer for the fixed-Huffman zlib encoder: buffers LZ77 symbols, pulses start,
// streams symbols once the encoder is in its block state, then waits for done under a watchdog.
module zlib_enc_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TMO_CYC    = 256,
  parameter int unsigned CNT_WD     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sym_val_i,
  output logic              sym_rdy_o,
  input  logic              sym_flg_lit_i,
  input  logic [7:0]        sym_lit_i,
  input  logic [6:0]        sym_len_i,
  input  logic [6:0]        sym_dis_i,
  input  logic              sym_lst_i,
  input  logic              sym_nul_i,
  output logic              enc_start_o,
  output logic              enc_val_o,
  output logic              enc_flg_lit_o,
  output logic [7:0]        enc_lit_o,
  output logic [6:0]        enc_len_o,
  output logic [6:0]        enc_dis_o,
  output logic              enc_lst_o,
  input  logic              enc_done_i,
  input  logic              clr_err_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [CNT_WD-1:0] frm_cnt_o,
  output logic [CNT_WD-1:0] sym_cnt_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [AW:0]   Full    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TmrLast = TW'(TMO_CYC - 1);

  typedef struct packed {
    logic       nul;
    logic       lst;
    logic       flg;
    logic [7:0] lit;
    logic [6:0] len;
    logic [6:0] dis;
  } sym_t;

  typedef enum logic [2:0] {StIdle, StStart, StHdr, StSym, StTail} state_t;

  state_t            r_state, w_state_nxt;
  sym_t              r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_cnt;
  logic              r_hdr;
  logic [TW-1:0]     r_tmr;
  logic              r_err;
  logic [CNT_WD-1:0] r_frm, r_sym;

  sym_t w_head;
  logic w_push, w_pop, w_empty, w_val, w_tmo, w_done;

  assign w_head    = r_mem[r_rptr];
  assign w_empty   = (r_cnt == '0);
  assign sym_rdy_o = (r_cnt != Full);
  assign w_push    = sym_val_i & sym_rdy_o;
  assign w_pop     = (r_state == StSym) & ~w_empty;
  assign w_val     = w_pop & ~w_head.nul;
  assign w_done    = (r_state == StTail) & enc_done_i;
  assign w_tmo     = (r_state == StTail) & ~enc_done_i & (r_tmr == TmrLast);

  // A nul beat only closes the frame, so it always carries last.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{nul: sym_nul_i, lst: sym_lst_i | sym_nul_i, flg: sym_flg_lit_i,
                         lit: sym_lit_i, len: sym_len_i, dis: sym_dis_i};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW + 1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_nxt = StStart;
      StStart: w_state_nxt = StHdr;
      StHdr:   if (r_hdr) w_state_nxt = StSym;
      StSym:   if (w_pop && w_head.lst) w_state_nxt = StTail;
      StTail:  if (w_done || w_tmo) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    enc_start_o   = (r_state == StStart);
    busy_o        = (r_state != StIdle);
    enc_val_o     = w_val;
    enc_lst_o     = w_pop & w_head.lst;
    enc_flg_lit_o = 1'b0;
    enc_lit_o     = '0;
    enc_len_o     = '0;
    enc_dis_o     = '0;
    if (w_val) begin
      enc_flg_lit_o = w_head.flg;
      enc_lit_o     = w_head.lit;
      enc_len_o     = w_head.len;
      enc_dis_o     = w_head.dis;
    end
  end

  // Header phase spans two cycles (CMF_FLG, BLK_0); r_hdr marks the second one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hdr <= 1'b0;
      r_tmr <= '0;
      r_err <= 1'b0;
      r_frm <= '0;
      r_sym <= '0;
    end else begin
      r_hdr <= (r_state == StHdr) ? ~r_hdr : 1'b0;
      r_tmr <= (r_state == StTail) ? r_tmr + TW'(1) : '0;
      if (w_tmo)          r_err <= 1'b1;
      else if (clr_err_i) r_err <= 1'b0;
      if (w_done) r_frm <= r_frm + CNT_WD'(1);
      if (r_state == StStart) r_sym <= '0;
      else if (w_val)         r_sym <= r_sym + CNT_WD'(1);
    end
  end

  assign err_o     = r_err;
  assign frm_cnt_o = r_frm;
  assign sym_cnt_o = r_sym;

endmodule
